// File: rtl/decode_pkg.sv
// Shared decode types, encoding constants and the opcode-to-control mapping
// used by the decode stage and its immediate extender.
package decode_pkg;

  localparam int IMM_TYPE_BITS_COUNT    = 3;
  localparam int ALU_OP_BITS_COUNT      = 2;
  localparam int BRANCH_TYPE_BITS_COUNT = 2;
  localparam int RESULT_SRC_BITS_COUNT  = 2;

  localparam logic [IMM_TYPE_BITS_COUNT-1:0] IMM_TYPE_I = 3'd0;
  localparam logic [IMM_TYPE_BITS_COUNT-1:0] IMM_TYPE_S = 3'd1;
  localparam logic [IMM_TYPE_BITS_COUNT-1:0] IMM_TYPE_B = 3'd2;
  localparam logic [IMM_TYPE_BITS_COUNT-1:0] IMM_TYPE_U = 3'd3;
  localparam logic [IMM_TYPE_BITS_COUNT-1:0] IMM_TYPE_J = 3'd4;

  localparam logic ALU_SRC2_GPR = 1'b0;
  localparam logic ALU_SRC2_IMM = 1'b1;

  localparam logic [ALU_OP_BITS_COUNT-1:0] ALU_OP_ADD = 2'd0;
  localparam logic [ALU_OP_BITS_COUNT-1:0] ALU_OP_SUB = 2'd1;
  localparam logic [ALU_OP_BITS_COUNT-1:0] ALU_OP_OTH = 2'd2;

  localparam logic [BRANCH_TYPE_BITS_COUNT-1:0] BRANCH_TYPE_NOT_BRANCH = 2'd0;
  localparam logic [BRANCH_TYPE_BITS_COUNT-1:0] BRANCH_TYPE_COND       = 2'd1;
  localparam logic [BRANCH_TYPE_BITS_COUNT-1:0] BRANCH_TYPE_JAL        = 2'd2;
  localparam logic [BRANCH_TYPE_BITS_COUNT-1:0] BRANCH_TYPE_JALR       = 2'd3;

  localparam logic [RESULT_SRC_BITS_COUNT-1:0] RESULT_SRC_ALU = 2'd0;
  localparam logic [RESULT_SRC_BITS_COUNT-1:0] RESULT_SRC_MEM = 2'd1;
  localparam logic [RESULT_SRC_BITS_COUNT-1:0] RESULT_SRC_PC4 = 2'd2;
  localparam logic [RESULT_SRC_BITS_COUNT-1:0] RESULT_SRC_IMM = 2'd3;

  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_REG      = 7'b0110011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_RV64_IMM = 7'b0011011;
  localparam logic [6:0] OP_RV64_REG = 7'b0111011;

  typedef struct packed {
    logic [IMM_TYPE_BITS_COUNT-1:0]    imm_type;
    logic                              alu_src2;
    logic [ALU_OP_BITS_COUNT-1:0]      alu_op;
    logic [BRANCH_TYPE_BITS_COUNT-1:0] branch_type;
    logic                              write_memory;
    logic                              write_gpr;
    logic [RESULT_SRC_BITS_COUNT-1:0]  result_src;
    logic                              is_word_op;
    logic                              illegal;
  } ctrl_t;

  // All-zero bundle with no side effects; also what every don't-care field falls back to.
  localparam ctrl_t CTRL_SAFE = '{
    imm_type:     IMM_TYPE_I,
    alu_src2:     ALU_SRC2_GPR,
    alu_op:       ALU_OP_ADD,
    branch_type:  BRANCH_TYPE_NOT_BRANCH,
    write_memory: 1'b0,
    write_gpr:    1'b0,
    result_src:   RESULT_SRC_ALU,
    is_word_op:   1'b0,
    illegal:      1'b0
  };

  function automatic ctrl_t decode_ctrl(input logic [31:0] instr, input logic rv64);
    ctrl_t c;
    c = CTRL_SAFE;
    case (instr[6:0])
      OP_LOAD: begin
        c.alu_src2 = ALU_SRC2_IMM;
        c.write_gpr = 1'b1;
        c.result_src = RESULT_SRC_MEM;
      end
      OP_STORE: begin
        c.imm_type = IMM_TYPE_S;
        c.alu_src2 = ALU_SRC2_IMM;
        c.write_memory = 1'b1;
      end
      OP_BRANCH: begin
        c.imm_type = IMM_TYPE_B;
        c.alu_op = ALU_OP_SUB;
        c.branch_type = BRANCH_TYPE_COND;
      end
      OP_JAL: begin
        c.imm_type = IMM_TYPE_J;
        c.branch_type = BRANCH_TYPE_JAL;
        c.write_gpr = 1'b1;
        c.result_src = RESULT_SRC_PC4;
      end
      OP_JALR: begin
        c.alu_src2 = ALU_SRC2_IMM;
        c.branch_type = BRANCH_TYPE_JALR;
        c.write_gpr = 1'b1;
        c.result_src = RESULT_SRC_PC4;
      end
      OP_IMM: begin
        c.alu_src2 = ALU_SRC2_IMM;
        c.alu_op = ALU_OP_OTH;
        c.write_gpr = 1'b1;
      end
      OP_REG: begin
        c.alu_op = ALU_OP_OTH;
        c.write_gpr = 1'b1;
      end
      OP_LUI: begin
        c.imm_type = IMM_TYPE_U;
        c.write_gpr = 1'b1;
        c.result_src = RESULT_SRC_IMM;
      end
      OP_AUIPC: begin
        c.imm_type = IMM_TYPE_U;
        c.alu_src2 = ALU_SRC2_IMM;
        c.write_gpr = 1'b1;
      end
      OP_RV64_IMM: begin
        c.alu_src2 = ALU_SRC2_IMM;
        c.alu_op = ALU_OP_OTH;
        c.write_gpr = 1'b1;
        c.is_word_op = 1'b1;
        c.illegal = ~rv64;
      end
      OP_RV64_REG: begin
        c.alu_op = ALU_OP_OTH;
        c.write_gpr = 1'b1;
        c.is_word_op = 1'b1;
        c.illegal = ~rv64;
      end
      default: c.illegal = 1'b1;
    endcase
    if (instr[1:0] != 2'b11) c.illegal = 1'b1;
    // An illegal encoding still flows down the pipe, but with every side effect removed.
    if (c.illegal) begin
      c = CTRL_SAFE;
      c.illegal = 1'b1;
    end
    if (instr[11:7] == 5'd0) c.write_gpr = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/imm_extender.sv
// Combinational immediate extraction; every format sign-extends from instr[31] to XLEN.
module imm_extender
  import decode_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]                    instr,
  input  logic [IMM_TYPE_BITS_COUNT-1:0] imm_type,
  output logic [XLEN-1:0]                imm
);

  logic signed [31:0] w_imm32;
  logic               w_unused_opcode;

  assign w_unused_opcode = ^instr[6:0];

  always_comb begin
    // NOTE: default assigned first so no path through the case leaves w_imm32 unassigned (no latch).
    w_imm32 = {{20{instr[31]}}, instr[31:20]};
    case (imm_type)
      IMM_TYPE_S: w_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_TYPE_B: w_imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_TYPE_U: w_imm32 = {instr[31:12], 12'b0};
      IMM_TYPE_J: w_imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:    w_imm32 = {{20{instr[31]}}, instr[31:20]};
    endcase
  end

  // Signed cast widens with sign extension; a no-op when XLEN is 32.
  assign imm = XLEN'(w_imm32);

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage between fetch and execute: valid/ready on both sides,
// one-entry skid buffer, synchronous flush and safe decode of every encoding.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int PC_WIDTH = XLEN
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [31:0]                       in_instr,
  input  logic [PC_WIDTH-1:0]               in_pc,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [PC_WIDTH-1:0]               out_pc,
  output logic [XLEN-1:0]                   out_imm,
  output logic [4:0]                        out_rd,
  output logic [4:0]                        out_rs1,
  output logic [4:0]                        out_rs2,
  output logic [2:0]                        out_funct3,
  output logic                              out_funct7_5,
  output logic [IMM_TYPE_BITS_COUNT-1:0]    out_imm_type,
  output logic                              out_alu_src2,
  output logic [ALU_OP_BITS_COUNT-1:0]      out_alu_op,
  output logic [BRANCH_TYPE_BITS_COUNT-1:0] out_branch_type,
  output logic                              out_write_memory,
  output logic                              out_write_gpr,
  output logic [RESULT_SRC_BITS_COUNT-1:0]  out_result_src,
  output logic                              out_is_word_op,
  output logic                              out_illegal
);

  localparam logic RV64 = (XLEN == 64);

  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_skid_valid;
  logic [31:0]         r_skid_instr;
  logic [PC_WIDTH-1:0] r_skid_pc;
  logic [PC_WIDTH-1:0] r_out_pc;
  logic [XLEN-1:0]     r_out_imm;
  logic [4:0]          r_out_rd;
  logic [4:0]          r_out_rs1;
  logic [4:0]          r_out_rs2;
  logic [2:0]          r_out_funct3;
  logic                r_out_funct7_5;
  ctrl_t               r_out_ctrl;

  logic                w_accept;
  logic                w_out_free;
  logic                w_load_out;
  logic                w_load_skid;
  logic                w_out_valid_nxt;
  logic                w_skid_valid_nxt;
  logic [31:0]         w_src_instr;
  logic [PC_WIDTH-1:0] w_src_pc;
  ctrl_t               w_ctrl;
  logic [XLEN-1:0]     w_imm;

  assign w_accept   = in_valid & r_in_ready;
  assign w_out_free = ~r_out_valid | out_ready;

  // The skid entry is always older than the input, so it takes the output register first.
  assign w_src_instr = r_skid_valid ? r_skid_instr : in_instr;
  assign w_src_pc    = r_skid_valid ? r_skid_pc : in_pc;

  assign w_ctrl = decode_ctrl(w_src_instr, RV64);

  imm_extender #(
    .XLEN(XLEN)
  ) u_imm_extender (
    .instr   (w_src_instr),
    .imm_type(w_ctrl.imm_type),
    .imm     (w_imm)
  );

  always_comb begin
    w_out_valid_nxt  = r_out_valid;
    w_skid_valid_nxt = r_skid_valid;
    w_load_out       = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      w_out_valid_nxt  = 1'b0;
      w_skid_valid_nxt = 1'b0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        w_out_valid_nxt  = 1'b1;
        w_skid_valid_nxt = 1'b0;
        w_load_out       = 1'b1;
      end else if (w_accept) begin
        w_out_valid_nxt = 1'b1;
        w_load_out      = 1'b1;
      end else begin
        w_out_valid_nxt = 1'b0;
      end
    end else if (w_accept) begin
      w_skid_valid_nxt = 1'b1;
      w_load_skid      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      r_out_valid  <= w_out_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= ~w_skid_valid_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: payload is reset as well so no X can ever leak through the source mux.
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
    end else if (w_load_skid) begin
      r_skid_instr <= in_instr;
      r_skid_pc    <= in_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_pc       <= '0;
      r_out_imm      <= '0;
      r_out_rd       <= '0;
      r_out_rs1      <= '0;
      r_out_rs2      <= '0;
      r_out_funct3   <= '0;
      r_out_funct7_5 <= 1'b0;
      r_out_ctrl     <= CTRL_SAFE;
    end else if (flush) begin
      r_out_pc       <= '0;
      r_out_imm      <= '0;
      r_out_rd       <= '0;
      r_out_rs1      <= '0;
      r_out_rs2      <= '0;
      r_out_funct3   <= '0;
      r_out_funct7_5 <= 1'b0;
      r_out_ctrl     <= CTRL_SAFE;
    end else if (w_load_out) begin
      r_out_pc       <= w_src_pc;
      r_out_imm      <= w_imm;
      r_out_rd       <= w_src_instr[11:7];
      r_out_rs1      <= w_src_instr[19:15];
      r_out_rs2      <= w_src_instr[24:20];
      r_out_funct3   <= w_src_instr[14:12];
      r_out_funct7_5 <= w_src_instr[30];
      r_out_ctrl     <= w_ctrl;
    end
  end

  assign in_ready         = r_in_ready;
  assign out_valid        = r_out_valid;
  assign out_pc           = r_out_pc;
  assign out_imm          = r_out_imm;
  assign out_rd           = r_out_rd;
  assign out_rs1          = r_out_rs1;
  assign out_rs2          = r_out_rs2;
  assign out_funct3       = r_out_funct3;
  assign out_funct7_5     = r_out_funct7_5;
  assign out_imm_type     = r_out_ctrl.imm_type;
  assign out_alu_src2     = r_out_ctrl.alu_src2;
  assign out_alu_op       = r_out_ctrl.alu_op;
  assign out_branch_type  = r_out_ctrl.branch_type;
  assign out_write_memory = r_out_ctrl.write_memory;
  assign out_write_gpr    = r_out_ctrl.write_gpr;
  assign out_result_src   = r_out_ctrl.result_src;
  assign out_is_word_op   = r_out_ctrl.is_word_op;
  assign out_illegal      = r_out_ctrl.illegal;

endmodule
